// File: rtl/vta_mem_pkg.sv
// Shared constants and FSM encoding for the VME tensor load/store clients.
package vta_mem_pkg;

  localparam int unsigned FIELD_W        = 16;
  localparam int unsigned DRAM_OFF_W     = 32;
  localparam int unsigned SRAM_OFF_LSB   = 9;
  localparam int unsigned DRAM_OFF_LSB   = 25;
  localparam int unsigned Y_SIZE_LSB     = 57;
  localparam int unsigned X_SIZE_LSB     = 73;
  localparam int unsigned X_STRIDE_LSB   = 89;

  localparam int unsigned TENSOR_BYTES     = 16;
  localparam int unsigned BEATS_PER_TENSOR = 2;
  localparam int unsigned MAX_BEATS        = 256;
  localparam int unsigned MAX_CHUNK        = MAX_BEATS / BEATS_PER_TENSOR;

  typedef enum logic [2:0] {StIdle, StCmd, StData, StAck, StDone} store_state_e;

endpackage

// File: rtl/tensor_beat_splitter.sv
// One-tensor buffer: captures a scratchpad read and emits it as two VME beats,
// low half first.
module tensor_beat_splitter import vta_mem_pkg::*; #(
  parameter int unsigned TENSOR_BITS = 128,
  parameter int unsigned BEAT_BITS   = TENSOR_BITS / BEATS_PER_TENSOR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_issue,
  input  logic                   rd_data_valid,
  input  logic [TENSOR_BITS-1:0] rd_data,
  output logic                   can_read,
  output logic                   beat_valid,
  output logic [BEAT_BITS-1:0]   beat_data,
  input  logic                   beat_ready
);

  logic [TENSOR_BITS-1:0] buf_q;
  logic                   full_q;
  logic                   hi_q;
  logic                   pend_q;
  logic                   beat_fire;

  assign beat_valid = full_q;
  assign beat_data  = hi_q ? buf_q[TENSOR_BITS-1 -: BEAT_BITS] : buf_q[BEAT_BITS-1:0];
  assign beat_fire  = full_q && beat_ready;
  // Buffer counts as free while its last beat leaves, so the next read overlaps it.
  assign can_read   = !pend_q && (!full_q || (hi_q && beat_ready));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_q  <= '0;
      full_q <= 1'b0;
      hi_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (rd_issue) begin
        pend_q <= 1'b1;
      end else if (rd_data_valid) begin
        pend_q <= 1'b0;
      end
      if (pend_q && rd_data_valid) begin
        buf_q  <= rd_data;
        full_q <= 1'b1;
        hi_q   <= 1'b0;
      end else if (beat_fire) begin
        if (hi_q) full_q <= 1'b0;
        hi_q <= !hi_q;
      end
    end
  end

endmodule

// File: rtl/tensor_store_out.sv
// VME write client: walks a 2-D region of the output scratchpad and stores it
// to DRAM as bursts of 64-bit beats, one burst in flight at a time.
module tensor_store_out import vta_mem_pkg::*; #(
  parameter int unsigned TENSOR_BITS = 128,
  parameter int unsigned BEAT_BITS   = 64,
  parameter int unsigned IDX_BITS    = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  output logic                   io_done,
  input  logic [127:0]           io_inst,
  input  logic [31:0]            io_baddr,
  input  logic                   io_vme_wr_cmd_ready,
  output logic                   io_vme_wr_cmd_valid,
  output logic [31:0]            io_vme_wr_cmd_bits_addr,
  output logic [7:0]             io_vme_wr_cmd_bits_len,
  input  logic                   io_vme_wr_data_ready,
  output logic                   io_vme_wr_data_valid,
  output logic [BEAT_BITS-1:0]   io_vme_wr_data_bits_data,
  output logic [BEAT_BITS/8-1:0] io_vme_wr_data_bits_strb,
  input  logic                   io_vme_wr_ack,
  output logic                   io_tensor_rd_idx_valid,
  output logic [IDX_BITS-1:0]    io_tensor_rd_idx_bits,
  input  logic                   io_tensor_rd_data_valid,
  input  logic [TENSOR_BITS-1:0] io_tensor_rd_data_bits
);

  store_state_e state_q, state_d;

  logic [FIELD_W-1:0]    sram_off_q, y_size_q, x_size_q, x_stride_q, x_q, y_q;
  logic [DRAM_OFF_W-1:0] dram_off_q;
  logic [7:0]            rd_cnt_q;
  logic [9:0]            beat_cnt_q;

  logic [FIELD_W-1:0]   remain, x_next;
  logic [8:0]           chunk;
  logic [9:0]           burst_beats;
  logic [31:0]          tensor_off;
  logic [IDX_BITS-1:0]  rd_idx;
  logic                 can_read, rd_issue, beat_valid, beat_ready, beat_fire;
  logic                 last_beat, row_end, zero_size;
  logic [BEAT_BITS-1:0] beat_data;
  logic                 unused_inst;

  assign unused_inst = ^{io_inst[SRAM_OFF_LSB-1:0], io_inst[127:X_STRIDE_LSB+FIELD_W]};

  assign remain      = x_size_q - x_q;
  assign chunk       = (remain > 16'(MAX_CHUNK)) ? 9'(MAX_CHUNK) : 9'(remain);
  assign burst_beats = {chunk, 1'b0};
  assign x_next      = x_q + 16'(chunk);
  assign row_end     = (x_next == x_size_q);
  assign zero_size   = (io_inst[X_SIZE_LSB +: FIELD_W] == '0) ||
                       (io_inst[Y_SIZE_LSB +: FIELD_W] == '0);

  assign tensor_off = dram_off_q + ({16'b0, y_q} * {16'b0, x_stride_q}) + {16'b0, x_q};
  // Index arithmetic is modulo the scratchpad depth, so truncate every term.
  assign rd_idx = IDX_BITS'(sram_off_q) + IDX_BITS'(y_q * x_size_q) + IDX_BITS'(x_q) +
                  IDX_BITS'(rd_cnt_q);

  assign rd_issue   = (state_q == StData) && can_read && ({1'b0, rd_cnt_q} < chunk);
  assign beat_ready = (state_q == StData) && io_vme_wr_data_ready;
  assign beat_fire  = io_vme_wr_data_valid && io_vme_wr_data_ready;
  assign last_beat  = (beat_cnt_q == burst_beats - 10'd1);

  assign io_vme_wr_cmd_bits_addr  = io_vme_wr_cmd_valid ?
                                    io_baddr + (tensor_off << $clog2(TENSOR_BYTES)) : '0;
  assign io_vme_wr_cmd_bits_len   = io_vme_wr_cmd_valid ? 8'(burst_beats - 10'd1) : '0;
  assign io_vme_wr_data_valid     = (state_q == StData) && beat_valid;
  assign io_vme_wr_data_bits_data = io_vme_wr_data_valid ? beat_data : '0;
  assign io_vme_wr_data_bits_strb = {(BEAT_BITS/8){io_vme_wr_data_valid}};
  assign io_tensor_rd_idx_valid   = rd_issue;
  assign io_tensor_rd_idx_bits    = rd_issue ? rd_idx : '0;

  tensor_beat_splitter #(
    .TENSOR_BITS (TENSOR_BITS),
    .BEAT_BITS   (BEAT_BITS)
  ) u_splitter (
    .clock         (clock),
    .reset         (reset),
    .rd_issue      (rd_issue),
    .rd_data_valid (io_tensor_rd_data_valid),
    .rd_data       (io_tensor_rd_data_bits),
    .can_read      (can_read),
    .beat_valid    (beat_valid),
    .beat_data     (beat_data),
    .beat_ready    (beat_ready)
  );

  always_comb begin
    state_d             = state_q;
    io_done             = 1'b0;
    io_vme_wr_cmd_valid = 1'b0;
    unique case (state_q)
      StIdle: if (io_start) state_d = zero_size ? StDone : StCmd;
      StCmd: begin
        io_vme_wr_cmd_valid = 1'b1;
        if (io_vme_wr_cmd_ready) state_d = StData;
      end
      StData: if (beat_fire && last_beat) state_d = StAck;
      StAck: begin
        if (io_vme_wr_ack) begin
          state_d = (row_end && (y_q + 16'd1 == y_size_q)) ? StDone : StCmd;
        end
      end
      StDone: begin
        io_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sram_off_q <= '0;
      dram_off_q <= '0;
      y_size_q   <= '0;
      x_size_q   <= '0;
      x_stride_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && io_start) begin
        sram_off_q <= io_inst[SRAM_OFF_LSB +: FIELD_W];
        dram_off_q <= io_inst[DRAM_OFF_LSB +: DRAM_OFF_W];
        y_size_q   <= io_inst[Y_SIZE_LSB +: FIELD_W];
        x_size_q   <= io_inst[X_SIZE_LSB +: FIELD_W];
        x_stride_q <= io_inst[X_STRIDE_LSB +: FIELD_W];
        x_q        <= '0;
        y_q        <= '0;
      end
      if (state_q == StCmd) begin
        rd_cnt_q   <= '0;
        beat_cnt_q <= '0;
      end
      if (rd_issue) rd_cnt_q <= rd_cnt_q + 8'd1;
      if (beat_fire) beat_cnt_q <= beat_cnt_q + 10'd1;
      if (state_q == StAck && io_vme_wr_ack) begin
        if (row_end) begin
          x_q <= '0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_next;
        end
      end
    end
  end

endmodule
